// File: rtl/instruction_fetch_unit.sv
// instruction_fetch_unit: holds the PC and fetches one instruction per step over a req/ack handshake
// Ports:
//    clk, rst_n                    clock and asynchronous active-low reset
//    imem_req/addr/ack/rdata       instruction memory read handshake
//    instrn, instrn_opcode, instrn_valid   registered instruction and its opcode field
//    pc, address_plus_4, branch_address, jump_address, sign_ext_out   current PC and candidate next addresses
//    next_pc, next_pc_accept       consumer hand-off of the next PC
//    fetch_err                     sticky error: fetch timeout or misaligned next_pc
module instruction_fetch_unit #(
   parameter logic [31:0] RESET_PC      = 32'h0000_0000,
   parameter int          FETCH_TIMEOUT = 16
) (
   input  logic        clk,
   input  logic        rst_n,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_ack,
   input  logic [31:0] imem_rdata,
   output logic [31:0] instrn,
   output logic [5:0]  instrn_opcode,
   output logic        instrn_valid,
   output logic [31:0] pc,
   output logic [31:0] address_plus_4,
   output logic [31:0] branch_address,
   output logic [31:0] jump_address,
   output logic [31:0] sign_ext_out,
   input  logic [31:0] next_pc,
   input  logic        next_pc_accept,
   output logic        fetch_err
);
   localparam int CW = $clog2(FETCH_TIMEOUT);
   typedef enum logic [1:0] {FETCH, HOLD, ERR} state_t;
   state_t        state;
   logic [CW-1:0] cnt;
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         state  <= FETCH;
         pc     <= RESET_PC;
         instrn <= '0;
         cnt    <= '0;
      end else
         case (state)
            FETCH:
               if (imem_ack) begin
                  instrn <= imem_rdata;
                  cnt    <= '0;
                  state  <= HOLD;
               end else if (cnt == CW'(FETCH_TIMEOUT - 1))
                  state <= ERR;
               else
                  cnt <= cnt + 1'b1;
            HOLD:
               if (next_pc_accept) begin
                  if (next_pc[1:0] == 2'b00) begin
                     pc    <= next_pc;
                     state <= FETCH;
                  end else
                     state <= ERR;
               end
            default: state <= ERR;
         endcase
   // reset state is FETCH, so the request is masked while reset is held
   assign imem_req       = rst_n && state == FETCH;
   assign imem_addr      = pc;
   assign instrn_valid   = state == HOLD;
   assign fetch_err      = state == ERR;
   assign instrn_opcode  = instrn[31:26];
   assign sign_ext_out   = {{16{instrn[15]}}, instrn[15:0]};
   assign address_plus_4 = pc + 32'd4;
   assign branch_address = address_plus_4 + {sign_ext_out[29:0], 2'b00};
   assign jump_address   = {address_plus_4[31:28], instrn[25:0], 2'b00};
endmodule

// File: tb/tb_instruction_fetch_unit.sv
// tb_instruction_fetch_unit: randomized transaction-level check of the fetch unit
module tb_instruction_fetch_unit;
   localparam logic [31:0] RESET_PC = 32'h0000_0000;
   localparam int FETCH_TIMEOUT = 16;
   logic        clk = 1'b0;
   logic        rst_n;
   logic        imem_req, imem_ack, instrn_valid, next_pc_accept, fetch_err;
   logic [31:0] imem_addr, imem_rdata, instrn, pc, address_plus_4, branch_address;
   logic [31:0] jump_address, sign_ext_out, next_pc;
   logic [5:0]  instrn_opcode;
   logic [31:0] mpc, minst, rv;
   int total = 0;
   int bad = 0;
   instruction_fetch_unit #(.RESET_PC(RESET_PC), .FETCH_TIMEOUT(FETCH_TIMEOUT)) dut (
      .clk(clk), .rst_n(rst_n), .imem_req(imem_req), .imem_addr(imem_addr),
      .imem_ack(imem_ack), .imem_rdata(imem_rdata), .instrn(instrn),
      .instrn_opcode(instrn_opcode), .instrn_valid(instrn_valid), .pc(pc),
      .address_plus_4(address_plus_4), .branch_address(branch_address),
      .jump_address(jump_address), .sign_ext_out(sign_ext_out), .next_pc(next_pc),
      .next_pc_accept(next_pc_accept), .fetch_err(fetch_err)
   );
   always #5 clk = ~clk;
   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask
   function automatic logic [31:0] exp_p4();
      return mpc + 32'd4;
   endfunction
   function automatic logic [31:0] exp_br();
      int off;
      off = int'($signed(minst[15:0]));
      return exp_p4() + 32'(off * 4);
   endfunction
   function automatic logic [31:0] exp_jmp();
      logic [31:0] p4;
      p4 = exp_p4();
      return (p4 & 32'hF000_0000) | ((minst & 32'h03FF_FFFF) * 4);
   endfunction
   task automatic check_derived();
      int off;
      off = int'($signed(minst[15:0]));
      chk("opcode", 32'(instrn_opcode), minst >> 26);
      chk("sext", sign_ext_out, 32'(off));
      chk("plus4", address_plus_4, exp_p4());
      chk("branch", branch_address, exp_br());
      chk("jump", jump_address, exp_jmp());
   endtask
   task automatic do_reset();
      rst_n = 1'b0;
      imem_ack = 1'b0;
      next_pc_accept = 1'b0;
      #1;
      chk("rst_req", 32'(imem_req), 0);
      chk("rst_pc", pc, RESET_PC);
      chk("rst_valid", 32'(instrn_valid), 0);
      chk("rst_err", 32'(fetch_err), 0);
      chk("rst_instrn", instrn, 0);
      chk("rst_plus4", address_plus_4, RESET_PC + 32'd4);
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      chk("rel_req", 32'(imem_req), 1);
      chk("rel_addr", imem_addr, RESET_PC);
      mpc = RESET_PC;
      minst = 0;
   endtask
   task automatic do_fetch(input logic [31:0] word, input int waits);
      for (int i = 0; i <= waits; i++) begin
         chk("f_req", 32'(imem_req), 1);
         chk("f_addr", imem_addr, mpc);
         chk("f_valid", 32'(instrn_valid), 0);
         chk("f_err", 32'(fetch_err), 0);
         imem_ack = (i == waits);
         imem_rdata = (i == waits) ? word : $urandom;
         @(negedge clk);
      end
      imem_ack = 1'b0;
      minst = word;
      chk("g_valid", 32'(instrn_valid), 1);
      chk("g_req", 32'(imem_req), 0);
      chk("g_instrn", instrn, word);
      check_derived();
   endtask
   task automatic do_hold(input int n, input logic [31:0] npc);
      for (int i = 0; i < n; i++) begin
         next_pc_accept = 1'b0;
         next_pc = $urandom;
         imem_ack = 1'($urandom_range(0, 1));
         imem_rdata = $urandom;
         @(negedge clk);
         chk("h_valid", 32'(instrn_valid), 1);
         chk("h_req", 32'(imem_req), 0);
         chk("h_pc", pc, mpc);
         chk("h_instrn", instrn, minst);
         check_derived();
      end
      imem_ack = 1'b0;
      next_pc = npc;
      next_pc_accept = 1'b1;
      @(negedge clk);
      next_pc_accept = 1'b0;
      if (npc[1:0] == 2'b00) begin
         mpc = npc;
         chk("a_valid", 32'(instrn_valid), 0);
         chk("a_req", 32'(imem_req), 1);
         chk("a_addr", imem_addr, mpc);
      end else begin
         chk("m_err", 32'(fetch_err), 1);
         chk("m_req", 32'(imem_req), 0);
         chk("m_valid", 32'(instrn_valid), 0);
         chk("m_pc", pc, mpc);
      end
   endtask
   task automatic err_sticky();
      for (int i = 0; i < 4; i++) begin
         imem_ack = 1'b1;
         imem_rdata = $urandom;
         next_pc_accept = 1'b1;
         rv = $urandom;
         next_pc = rv & 32'hFFFF_FFFC;
         @(negedge clk);
         chk("s_err", 32'(fetch_err), 1);
         chk("s_req", 32'(imem_req), 0);
         chk("s_valid", 32'(instrn_valid), 0);
         chk("s_pc", pc, mpc);
      end
      imem_ack = 1'b0;
      next_pc_accept = 1'b0;
   endtask
   initial begin
      rst_n = 1'b1;
      imem_ack = 1'b0;
      imem_rdata = 0;
      next_pc = 0;
      next_pc_accept = 1'b0;
      #2;
      do_reset();
      do_fetch(32'h8C22_0004, 0);
      do_hold(1, 32'h10);
      do_fetch(32'h1000_FFFF, 1);
      chk("beq_target", branch_address, 32'h10);
      do_hold(2, 32'h10);
      do_fetch(32'h1000_FFFF, 0);
      do_hold(0, 32'h4000_0000);
      do_fetch(32'h0800_0040, 2);
      chk("j_target", jump_address, 32'h4000_0100);
      do_hold(1, exp_jmp());
      chk("j_addr", imem_addr, 32'h4000_0100);
      do_fetch($urandom, 3);
      do_hold(5, 32'h200);
      for (int k = 0; k < 20; k++) begin
         do_fetch($urandom, int'($urandom_range(0, 6)));
         rv = $urandom;
         case ($urandom_range(0, 3))
            0: rv = exp_p4();
            1: rv = exp_br();
            2: rv = exp_jmp();
            default: rv = rv & 32'hFFFF_FFFC;
         endcase
         do_hold(int'($urandom_range(0, 3)), rv);
      end
      do_fetch($urandom, 1);
      do_hold(1, 32'hFFFF_FFFC);
      do_fetch($urandom, 0);
      chk("wrap_plus4", address_plus_4, 32'h0);
      do_hold(1, 32'h22);
      err_sticky();
      rst_n = 1'b0;
      #1;
      chk("err_rst_err", 32'(fetch_err), 0);
      chk("err_rst_pc", pc, RESET_PC);
      @(negedge clk);
      do_reset();
      do_fetch($urandom, FETCH_TIMEOUT - 1);
      do_hold(1, 32'h100);
      for (int i = 0; i < FETCH_TIMEOUT; i++) begin
         chk("t_req", 32'(imem_req), 1);
         chk("t_err", 32'(fetch_err), 0);
         imem_ack = 1'b0;
         @(negedge clk);
      end
      chk("to_err", 32'(fetch_err), 1);
      chk("to_req", 32'(imem_req), 0);
      chk("to_pc", pc, 32'h100);
      err_sticky();
      do_reset();
      do_fetch($urandom, 2);
      do_hold(1, 32'h40);
      repeat (5) @(negedge clk);
      imem_ack = 1'b1;
      imem_rdata = 32'hDEAD_BEEF;
      rst_n = 1'b0;
      #1;
      chk("mid_pc", pc, RESET_PC);
      chk("mid_req", 32'(imem_req), 0);
      chk("mid_err", 32'(fetch_err), 0);
      @(negedge clk);
      chk("mid_valid", 32'(instrn_valid), 0);
      chk("mid_instrn", instrn, 0);
      imem_ack = 1'b0;
      rst_n = 1'b1;
      #1;
      chk("mid_rel_req", 32'(imem_req), 1);
      chk("mid_rel_addr", imem_addr, RESET_PC);
      mpc = RESET_PC;
      @(negedge clk);
      do_fetch(32'h8C22_0004, 1);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/instruction_fetch_unit.md
Name: instruction_fetch_unit

Overview:
Fetch stage directly upstream of the single-cycle control/datapath logic. Holds the PC and fetches one instruction per step from instruction memory over a req/ack handshake. Presents the decoded fields and candidate next addresses (PC+4, branch, jump). Loads the next PC chosen by control when the consumer accepts the current instruction.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset; must be word aligned.
FETCH_TIMEOUT, 16, max cycles in FETCH without ack before fetch error (>=2).

Ports:
clk  in  1  system clock, rising edge.
rst_n  in  1  asynchronous active-low reset.
imem_req  out  1  instruction read request.
imem_addr  out  32  read address, equals pc.
imem_ack  in  1  read data valid this cycle; only meaningful while imem_req=1.
imem_rdata  in  32  instruction word, sampled when imem_ack=1.
instrn  out  32  registered instruction.
instrn_opcode  out  6  instrn[31:26].
instrn_valid  out  1  instrn and derived outputs valid.
pc  out  32  current program counter.
address_plus_4  out  32  pc+4.
branch_address  out  32  address_plus_4 + (sign_ext_out<<2).
jump_address  out  32  {address_plus_4[31:28], instrn[25:0], 2'b00}.
sign_ext_out  out  32  instrn[15:0] sign-extended.
next_pc  in  32  next address selected by control.
next_pc_accept  in  1  consumer done with instrn; load next_pc.
fetch_err  out  1  sticky error: timeout or misaligned next_pc.

Behaviour:
- Reset (async, rst_n=0): pc=RESET_PC, state=FETCH, instrn=0, instrn_valid=0, fetch_err=0, timeout counter=0. imem_req is 0 while rst_n=0. imem_req first rises in the first cycle after rst_n deasserts.
- State FETCH:
  - imem_req=1, imem_addr=pc, both stable until ack.
  - imem_ack=1 at an edge: instrn<=imem_rdata, instrn_valid<=1, counter<=0, next state HOLD.
  - Zero-wait ack is legal: ack in the first req cycle gives instrn_valid the next cycle.
  - No ack: counter increments. When the counter reaches FETCH_TIMEOUT-1 without ack, next state ERR.
- State HOLD:
  - imem_req=0; instrn, pc and all derived outputs stable.
  - next_pc_accept=1: if next_pc[1:0]==0, pc<=next_pc, instrn_valid<=0, next state FETCH.
  - next_pc_accept=1 with next_pc[1:0]!=0: next state ERR, pc unchanged.
- State ERR: imem_req=0, instrn_valid=0, fetch_err=1. Held until reset; all inputs ignored.
- next_pc_accept outside HOLD is ignored. imem_ack outside FETCH is ignored.
- Minimum throughput: 2 cycles per instruction (FETCH with ack, then HOLD with accept).
- Arithmetic is modulo 2^32: pc=32'hFFFF_FFFC gives address_plus_4=0. branch_address wraps likewise.
- Derived outputs are combinational from pc/instrn. They are valid only while instrn_valid=1 but defined at all times (reset: address_plus_4=RESET_PC+4, others 0/derived).
- Reset asserted mid-FETCH or mid-HOLD: immediate return to reset values. Any in-flight ack is discarded.

Test Plan:
- Reset release, zero-wait memory returning 32'h8C22_0004 at addr 0 -> imem_addr=0 for 1 cycle; next cycle instrn_valid=1, instrn_opcode=6'h23, address_plus_4=4, sign_ext_out=4.
- pc=32'h10, instrn=32'h1000_FFFF (beq, offset -1) -> branch_address=32'h10. Accept with next_pc=32'h10 -> refetch at addr 32'h10.
- pc=32'h4000_0000, instrn=32'h0800_0040 (j) -> jump_address=32'h4000_0100. Accept with next_pc=jump_address -> imem_addr=32'h4000_0100.
- Memory with 3 wait states -> imem_req and imem_addr stable for 4 cycles, instrn_valid=0 until the cycle after ack. Holding next_pc_accept=0 for 5 cycles in HOLD -> outputs unchanged, imem_req=0.
- No ack for 16 cycles (FETCH_TIMEOUT=16) -> fetch_err=1, imem_req=0, sticky. Asserting rst_n=0 mid-wait -> pc=RESET_PC, fetch_err=0 immediately.
- Accept with next_pc=32'h22 -> fetch_err=1, pc unchanged. Separately, pc=32'hFFFF_FFFC -> address_plus_4=0.
